// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_BITS       = 16;
  localparam int unsigned BYTE_BITS      = 8;
  localparam int unsigned WORD_BITS      = BYTES_PER_WORD * BYTE_BITS;

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream; flags the cycle the 4th byte lands.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 byte_valid_i,
  input  logic [BYTE_BITS-1:0] byte_i,
  output logic                 word_valid_c,
  output logic [WORD_BITS-1:0] word_c
);

  localparam int unsigned CNT_BITS = $clog2(BYTES_PER_WORD);

  logic [CNT_BITS-1:0]  byte_cnt_q, byte_cnt_d;
  logic [WORD_BITS-1:0] asm_q, asm_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    if (clear_i) begin
      byte_cnt_d = '0;
      asm_d      = '0;
    end else if (byte_valid_i) begin
      asm_d[32'(byte_cnt_q) * BYTE_BITS +: BYTE_BITS] = byte_i;
      byte_cnt_d = byte_cnt_q + CNT_BITS'(1);
    end
  end

  // The top byte bypasses the register so the word is available on the accepting edge.
  assign word_valid_c = byte_valid_i && !clear_i &&
                        (byte_cnt_q == CNT_BITS'(BYTES_PER_WORD - 1));
  assign word_c       = {byte_i, asm_q[WORD_BITS-BYTE_BITS-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed image into instruction memory, then releases core reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned i_addr_bits = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BYTE_BITS-1:0]   in_data,
  input  logic                   reload,
  output logic                   im_we,
  output logic [i_addr_bits-1:0] im_addr,
  output logic [WORD_BITS-1:0]   im_wdata,
  output logic                   core_rst_n,
  output logic                   loaded,
  output logic                   err
);

  localparam int unsigned DEPTH = 1 << i_addr_bits;

  state_e                 state_q, state_d;
  logic [HDR_BITS-1:0]    n_words_q, n_words_d;
  logic [i_addr_bits:0]   word_cnt_q, word_cnt_d;
  logic                   in_ready_q, in_ready_d;
  logic                   im_we_q, im_we_d;
  logic [i_addr_bits-1:0] im_addr_q, im_addr_d;
  logic [WORD_BITS-1:0]   im_wdata_q, im_wdata_d;
  logic                   core_rst_n_q, core_rst_n_d;
  logic                   loaded_q, loaded_d;
  logic                   err_q, err_d;

  logic                   accept_c;
  logic                   pack_clear_c;
  logic                   word_valid_c;
  logic [WORD_BITS-1:0]   word_c;
  logic [HDR_BITS-1:0]    hdr_c;

  assign accept_c = in_valid && in_ready_q;
  assign hdr_c    = {in_data, n_words_q[BYTE_BITS-1:0]};

  imem_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (pack_clear_c),
    .byte_valid_i (accept_c && (state_q == S_LOAD)),
    .byte_i       (in_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    n_words_d    = n_words_q;
    word_cnt_d   = word_cnt_q;
    im_we_d      = 1'b0;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;
    pack_clear_c = 1'b0;

    unique case (state_q)
      S_HDR0: begin
        if (accept_c) begin
          n_words_d[BYTE_BITS-1:0] = in_data;
          state_d                  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept_c) begin
          n_words_d    = hdr_c;
          word_cnt_d   = '0;
          pack_clear_c = 1'b1;
          if (hdr_c == '0)                state_d = S_RUN;
          else if (32'(hdr_c) > DEPTH)    state_d = S_ERR;
          else                            state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (word_valid_c) begin
          im_we_d    = 1'b1;
          im_addr_d  = word_cnt_q[i_addr_bits-1:0];
          im_wdata_d = word_c;
          word_cnt_d = word_cnt_q + (i_addr_bits+1)'(1);
          if (32'(word_cnt_q) + 32'd1 == 32'(n_words_q)) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (reload) begin
          state_d      = S_HDR0;
          n_words_d    = '0;
          word_cnt_d   = '0;
          pack_clear_c = 1'b1;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_HDR0;
      end
    endcase

    in_ready_d   = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_LOAD);
    // Core release lags entry into S_RUN by one edge so the last write completes first.
    core_rst_n_d = (state_q == S_RUN) && (state_d == S_RUN);
    loaded_d     = core_rst_n_d;
    err_d        = err_q || (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HDR0;
      n_words_q    <= '0;
      word_cnt_q   <= '0;
      in_ready_q   <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      core_rst_n_q <= 1'b0;
      loaded_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_words_q    <= n_words_d;
      word_cnt_q   <= word_cnt_d;
      in_ready_q   <= in_ready_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      loaded_q     <= loaded_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign loaded     = loaded_q;
  assign err        = err_q;

endmodule
